// File: rtl/gerenciador_estabelecidos_mp.sv
// rtl/gerenciador_estabelecidos_mp.sv - multi-read-port established-state store with sequenced clear
module gerenciador_estabelecidos_mp #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_RD     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear_start_in,
  output logic                           busy_out,
  input  logic                           write_en_in,
  input  logic [ADDR_WIDTH-1:0]          write_addr_in,
  input  logic [DATA_WIDTH-1:0]          write_data_in,
  input  logic [NUM_RD-1:0]              rd_en_in,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr_in,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data_out,
  output logic [NUM_RD-1:0]              rd_valid_out,
  output logic [ADDR_WIDTH:0]            count_out,
  output logic                           all_set_out
);

  localparam int MEM_SIZE = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR   = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   ONE        = (ADDR_WIDTH+1)'(1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                         state_q;
  logic                           busy_q;
  logic [ADDR_WIDTH-1:0]          clr_ptr_q;
  logic [ADDR_WIDTH:0]            count_q;
  logic [ADDR_WIDTH:0]            count_d;
  logic                           all_set_q;
  logic [NUM_RD-1:0]              rd_valid_q;
  logic [NUM_RD*DATA_WIDTH-1:0]   rd_data_q;
  logic [DATA_WIDTH-1:0]          mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0]          rd_word [NUM_RD];
  logic [DATA_WIDTH-1:0]          old_data;
  logic                           wr_accept;

  // A clear request wins over a write issued in the same cycle.
  assign wr_accept = (state_q == IDLE) && write_en_in && !clear_start_in;
  assign old_data  = mem[write_addr_in];

  always_comb begin
    count_d = count_q;
    if (state_q == IDLE && clear_start_in) begin
      count_d = '0;
    end else if (wr_accept) begin
      if (old_data == '0 && write_data_in != '0) begin
        count_d = count_q + ONE;
      end else if (old_data != '0 && write_data_in == '0) begin
        count_d = count_q - ONE;
      end
    end
  end

  // Busy reads return 0; otherwise a same-cycle accepted write is forwarded.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_word[p] = '0;
      if (state_q == IDLE) begin
        if (wr_accept && write_addr_in == rd_addr_in[p*ADDR_WIDTH +: ADDR_WIDTH]) begin
          rd_word[p] = write_data_in;
        end else begin
          rd_word[p] = mem[rd_addr_in[p*ADDR_WIDTH +: ADDR_WIDTH]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_ptr_q] <= '0;
    end else if (wr_accept) begin
      mem[write_addr_in] <= write_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      busy_q     <= 1'b1;
      clr_ptr_q  <= '0;
      count_q    <= '0;
      all_set_q  <= 1'b0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      count_q    <= count_d;
      all_set_q  <= (count_d == FULL_COUNT);
      rd_valid_q <= rd_en_in;
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en_in[p]) begin
          rd_data_q[p*DATA_WIDTH +: DATA_WIDTH] <= rd_word[p];
        end
      end
      case (state_q)
        IDLE: begin
          if (clear_start_in) begin
            state_q   <= CLEAR;
            busy_q    <= 1'b1;
            clr_ptr_q <= '0;
          end
        end
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LAST_PTR) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= CLEAR;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy_out     = busy_q;
  assign count_out    = count_q;
  assign all_set_out  = all_set_q;
  assign rd_valid_out = rd_valid_q;
  assign rd_data_out  = rd_data_q;

endmodule

// File: tb/tb_gerenciador_estabelecidos_mp.sv
// tb/tb_gerenciador_estabelecidos_mp.sv - scoreboard bench for two configurations of the store
module tb_gerenciador_estabelecidos_mp;

  localparam int MS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clr, we;
  logic [3:0] waddr;
  logic [2:0] wdata;
  logic [3:0] ren;
  logic [3:0] raddr [4];
  logic [15:0] ra_b;
  logic [7:0]  ra_a;
  assign ra_b = {raddr[3], raddr[2], raddr[1], raddr[0]};
  assign ra_a = {raddr[1], raddr[0]};

  logic        busy_a, all_a, busy_b, all_b;
  logic [1:0]  rdd_a, rdv_a;
  logic [11:0] rdd_b;
  logic [3:0]  rdv_b;
  logic [4:0]  cnt_a, cnt_b;

  gerenciador_estabelecidos_mp #(.DATA_WIDTH(1), .ADDR_WIDTH(4), .NUM_RD(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear_start_in(clr), .busy_out(busy_a),
    .write_en_in(we), .write_addr_in(waddr), .write_data_in(wdata[0]),
    .rd_en_in(ren[1:0]), .rd_addr_in(ra_a), .rd_data_out(rdd_a), .rd_valid_out(rdv_a),
    .count_out(cnt_a), .all_set_out(all_a)
  );

  gerenciador_estabelecidos_mp #(.DATA_WIDTH(3), .ADDR_WIDTH(4), .NUM_RD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear_start_in(clr), .busy_out(busy_b),
    .write_en_in(we), .write_addr_in(waddr), .write_data_in(wdata),
    .rd_en_in(ren), .rd_addr_in(ra_b), .rd_data_out(rdd_b), .rd_valid_out(rdv_b),
    .count_out(cnt_b), .all_set_out(all_b)
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  en;
    logic [11:0] v;
    logic        busy;
    logic [4:0]  ca;
    logic [4:0]  cb;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] m_mem [MS];
  int         busy_left = 0;
  bit         mon_en = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_count(input bit bit0_only);
    int c = 0;
    for (int i = 0; i < MS; i++)
      if (bit0_only ? m_mem[i][0] : (m_mem[i] != 3'd0)) c++;
    return c;
  endfunction

  // Applies the current inputs for one clock, predicting the response from the model.
  task automatic tick();
    exp_t e;
    logic [2:0] v;
    e = '0;
    e.rst = !rst_n;
    for (int p = 0; p < 4; p++) begin
      if (ren[p] && rst_n) begin
        e.en[p] = 1'b1;
        if (busy_left > 0) v = 3'd0;
        else if (we && !clr && waddr == raddr[p]) v = wdata;
        else v = m_mem[raddr[p]];
        e.v[p*3 +: 3] = v;
      end
    end
    if (!rst_n || (busy_left == 0 && clr)) begin
      busy_left = MS;
      for (int i = 0; i < MS; i++) m_mem[i] = 3'd0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (we) begin
      m_mem[waddr] = wdata;
    end
    e.busy = (busy_left > 0);
    e.ca = 5'(model_count(1'b1));
    e.cb = 5'(model_count(1'b0));
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  task automatic quiet();
    we = 1'b0; clr = 1'b0; ren = 4'd0; waddr = 4'd0; wdata = 3'd0;
    for (int p = 0; p < 4; p++) raddr[p] = 4'd0;
  endtask

  task automatic wr(input int a, input int d);
    quiet(); we = 1'b1; waddr = 4'(a); wdata = 3'(d); tick();
  endtask

  task automatic read_all();
    for (int a = 0; a < MS; a++) begin
      quiet(); ren = 4'hF;
      for (int p = 0; p < 4; p++) raddr[p] = 4'(a + p);
      tick();
    end
  endtask

  exp_t       me;
  logic [2:0] last_b [4];
  logic [2:0] vb;

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        me = exp_q.pop_front();
        if (me.rst) for (int p = 0; p < 4; p++) last_b[p] = 3'd0;
        chk("busy_a", int'(busy_a), int'(me.busy));
        chk("busy_b", int'(busy_b), int'(me.busy));
        chk("count_a", int'(cnt_a), int'(me.ca));
        chk("count_b", int'(cnt_b), int'(me.cb));
        chk("all_set_a", int'(all_a), int'(me.ca == 5'd16));
        chk("all_set_b", int'(all_b), int'(me.cb == 5'd16));
        for (int p = 0; p < 4; p++) begin
          vb = me.en[p] ? me.v[p*3 +: 3] : last_b[p];
          last_b[p] = vb;
          chk($sformatf("rd_valid_b%0d", p), int'(rdv_b[p]), int'(me.en[p]));
          chk($sformatf("rd_data_b%0d", p), int'(rdd_b[p*3 +: 3]), int'(vb));
          if (p < 2) begin
            chk($sformatf("rd_valid_a%0d", p), int'(rdv_a[p]), int'(me.en[p]));
            chk($sformatf("rd_data_a%0d", p), int'(rdd_a[p]), int'(vb[0]));
          end
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < 4; p++) last_b[p] = 3'd0;
    for (int i = 0; i < MS; i++) m_mem[i] = 3'd0;
    quiet();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset sweep with reads on every port, then all addresses once idle.
    read_all();
    quiet(); tick();
    read_all();

    // Simple write then read of a written and an unwritten address.
    wr(3, 1);
    quiet(); ren = 4'h3; raddr[0] = 4'd3; raddr[1] = 4'd4; tick();

    // Bypass on all ports, rewrite, then clear of the entry.
    quiet(); we = 1'b1; waddr = 4'd7; wdata = 3'd1; ren = 4'hF;
    for (int p = 0; p < 4; p++) raddr[p] = 4'd7;
    tick();
    wr(7, 1);
    wr(7, 0);

    // Fill the whole store, then sweep-clear it.
    for (int a = 0; a < MS; a++) wr(a, {$urandom_range(0, 3), 1'b1});
    quiet(); tick();
    quiet(); clr = 1'b1; tick();
    read_all();
    read_all();

    // Events during a sweep: dropped write, ignored clear, restarting reset.
    quiet(); clr = 1'b1; tick();
    for (int i = 0; i < 11; i++) begin
      quiet();
      if (i == 5) begin we = 1'b1; waddr = 4'd2; wdata = 3'd5; end
      if (i == 8) clr = 1'b1;
      if (i == 10) rst_n = 1'b0;
      tick();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) begin quiet(); tick(); end

    // Multi-bit data across four ports.
    wr(2, 5); wr(9, 0); wr(15, 7);
    quiet(); ren = 4'hF;
    raddr[0] = 4'd2; raddr[1] = 4'd9; raddr[2] = 4'd15; raddr[3] = 4'd2;
    tick();

    // Randomized traffic with bypass-biased read addresses.
    for (int i = 0; i < 600; i++) begin
      we    = 1'($urandom_range(0, 1));
      waddr = 4'($urandom);
      wdata = 3'($urandom);
      ren   = 4'($urandom);
      clr   = ($urandom_range(0, 59) == 0);
      rst_n = ($urandom_range(0, 249) != 0);
      for (int p = 0; p < 4; p++)
        raddr[p] = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
      tick();
    end
    rst_n = 1'b1;
    quiet(); tick(); tick();

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
